// File: rtl/alu_param.sv
// ============================================================================
// alu_param : N-bit ALU with combinational result/flags and a registered
//             copy of the flags.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_param #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   ALUControl,
  input  logic [1:0]   ALUFlagIn,
  output logic [N-1:0] ALUResult,
  output logic [1:0]   ALUFlags,
  output logic [1:0]   C_Flag
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_INC = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam logic [N-1:0] SHAMT_FULL = N'(N);

  logic         cin;
  logic         unused_flag_in;
  logic [N-1:0] x_sel;
  logic [N:0]   add_sum;
  logic [N:0]   a_plus_cin;
  logic [N:0]   shl_ext;
  logic [N:0]   shr_ext;
  logic [N-1:0] shl_ones;
  logic [N-1:0] shr_ones;
  logic [N-1:0] result;
  logic         carry;

  assign cin            = ALUFlagIn[0];
  assign unused_flag_in = ALUFlagIn[1];
  assign x_sel          = cin ? B : A;

  assign add_sum    = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, cin};
  assign a_plus_cin = {1'b0, A} + {{N{1'b0}}, cin};

  // One guard bit beside the operand catches the bit shifted out; large
  // amounts naturally leave only zeros in both the result and the guard.
  assign shl_ext  = {1'b0, A} << B;
  assign shr_ext  = {A, 1'b0} >> B;
  assign shl_ones = ~((~A) << B);
  assign shr_ones = ~((~A) >> B);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (ALUControl)
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_ADD: begin
        result = add_sum[N-1:0];
        carry  = add_sum[N];
      end
      OP_INC: begin
        result = x_sel + 1'b1;
        carry  = &x_sel;
      end
      OP_DEC: begin
        result = x_sel - 1'b1;
        carry  = (x_sel == '0);
      end
      OP_NOT: result = ~x_sel;
      OP_SUB: begin
        result = a_plus_cin[N-1:0] - B;
        carry  = (a_plus_cin < {1'b0, B});
      end
      OP_XOR: result = A ^ B;
      OP_SHL: begin
        result = cin ? shl_ones : shl_ext[N-1:0];
        carry  = (B == SHAMT_FULL) ? A[N-1] : shl_ext[N];
      end
      OP_SHR: begin
        result = cin ? shr_ones : shr_ext[N:1];
        carry  = (B == SHAMT_FULL) ? A[0] : shr_ext[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign ALUResult = result;
  assign ALUFlags  = {(result == '0), carry};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      C_Flag <= 2'b00;
    end else begin
      C_Flag <= ALUFlags;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_param.sv
// ============================================================================
// tb_alu_param : table-driven check of alu_param (N=4) plus reset/flag
//                register sequences and a randomised sweep.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_alu_param;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] op;
  logic [1:0] flag_in;
  logic [3:0] alu_result;
  logic [1:0] alu_flags;
  logic [1:0] c_flag;

  int tests_run;
  int tests_failed;

  alu_param #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (a),
    .B          (b),
    .ALUControl (op),
    .ALUFlagIn  (flag_in),
    .ALUResult  (alu_result),
    .ALUFlags   (alu_flags),
    .C_Flag     (c_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] fin;
    logic [3:0] res;
    logic [1:0] flags;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [3:0] vop, va, vb,
                         input logic [1:0] vfin, input logic [3:0] vres,
                         input logic [1:0] vflags);
    vec_t v;
    v.name = name; v.op = vop; v.a = va; v.b = vb;
    v.fin = vfin; v.res = vres; v.flags = vflags;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: shifts are done one bit at a time.
  function automatic void model(input logic [3:0] mop, ma, mb, input logic mcin,
                                output logic [3:0] r, output logic c);
    logic [3:0] x;
    logic [3:0] v;
    int         s;
    x = mcin ? mb : ma;
    r = 4'd0;
    c = 1'b0;
    case (mop)
      4'd0: r = ma & mb;
      4'd1: r = ma | mb;
      4'd2: begin s = int'(ma) + int'(mb) + int'(mcin); r = s[3:0]; c = (s > 15); end
      4'd3: begin s = int'(x) + 1; r = s[3:0]; c = (x == 4'hF); end
      4'd4: begin s = int'(x) - 1; r = s[3:0]; c = (x == 4'h0); end
      4'd5: r = ~x;
      4'd6: begin
        s = int'(ma) + int'(mcin) - int'(mb);
        r = s[3:0];
        c = (int'(ma) + int'(mcin)) < int'(mb);
      end
      4'd7: r = ma ^ mb;
      4'd8, 4'd9: begin
        v = ma;
        for (int i = 0; i < int'(mb); i++) begin
          if (mop == 4'd8) begin c = v[3]; v = {v[2:0], mcin}; end
          else             begin c = v[0]; v = {mcin, v[3:1]}; end
        end
        r = v;
        if (mb == 4'd0 || mb > 4'd4) c = 1'b0;
        else if (mb == 4'd4) c = (mop == 4'd8) ? ma[3] : ma[0];
      end
      default: begin r = 4'd0; c = 1'b0; end
    endcase
  endfunction

  logic [3:0] m_res;
  logic       m_c;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    a       = 4'd0;
    b       = 4'd0;
    op      = 4'd0;
    flag_in = 2'b00;

    add_vec("add_9_8_c1",   4'd2,  4'd9,  4'd8,  2'b01, 4'h2, 2'b01);
    add_vec("add_wrap_z",   4'd2,  4'hF,  4'h0,  2'b01, 4'h0, 2'b11);
    add_vec("sub_3_5",      4'd6,  4'd3,  4'd5,  2'b00, 4'hE, 2'b01);
    add_vec("sub_3_5_c1",   4'd6,  4'd3,  4'd5,  2'b01, 4'hF, 2'b01);
    add_vec("sub_5_5",      4'd6,  4'd5,  4'd5,  2'b00, 4'h0, 2'b10);
    add_vec("inc_b15",      4'd3,  4'd3,  4'hF,  2'b01, 4'h0, 2'b11);
    add_vec("dec_a0",       4'd4,  4'd0,  4'd7,  2'b00, 4'hF, 2'b01);
    add_vec("not_b5",       4'd5,  4'd0,  4'h5,  2'b01, 4'hA, 2'b00);
    add_vec("shl_ones",     4'd8,  4'h3,  4'd2,  2'b01, 4'hF, 2'b00);
    add_vec("shl_zeros",    4'd8,  4'h3,  4'd2,  2'b00, 4'hC, 2'b00);
    add_vec("shl_full",     4'd8,  4'h8,  4'd4,  2'b00, 4'h0, 2'b11);
    add_vec("shr_ones",     4'd9,  4'h8,  4'd1,  2'b01, 4'hC, 2'b00);
    add_vec("shr_over",     4'd9,  4'hB,  4'd5,  2'b00, 4'h0, 2'b10);
    add_vec("shr_full_one", 4'd9,  4'h1,  4'd4,  2'b01, 4'hF, 2'b01);
    add_vec("and",          4'd0,  4'hC,  4'hA,  2'b00, 4'h8, 2'b00);
    add_vec("or",           4'd1,  4'hC,  4'hA,  2'b00, 4'hE, 2'b00);
    add_vec("xor",          4'd7,  4'hC,  4'hA,  2'b00, 4'h6, 2'b00);
    add_vec("op12",         4'd12, 4'hF,  4'hF,  2'b01, 4'h0, 2'b10);

    // Reset state of the flag register.
    repeat (2) @(posedge clk);
    #1;
    check("reset_c_flag", {6'd0, c_flag}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; flag_in = vecs[i].fin;
      #1;
      check({vecs[i].name, "_res"},   {4'd0, alu_result}, {4'd0, vecs[i].res});
      check({vecs[i].name, "_flags"}, {6'd0, alu_flags},  {6'd0, vecs[i].flags});
      flag_in = vecs[i].fin ^ 2'b10;
      #1;
      check({vecs[i].name, "_res_f1"},   {4'd0, alu_result}, {4'd0, vecs[i].res});
      check({vecs[i].name, "_flags_f1"}, {6'd0, alu_flags},  {6'd0, vecs[i].flags});
    end

    // Registered flags follow one edge later.
    @(negedge clk);
    op = 4'd2; a = 4'd9; b = 4'd8; flag_in = 2'b01;
    @(posedge clk);
    #1;
    check("c_flag_add", {6'd0, c_flag}, 8'h01);

    // Reset holds the register clear even with both flags set.
    @(negedge clk);
    op = 4'd3; a = 4'd3; b = 4'hF; flag_in = 2'b01; rst_n = 1'b0;
    #1;
    check("flags_live_in_reset", {6'd0, alu_flags}, 8'h03);
    @(posedge clk);
    #1;
    check("c_flag_in_reset", {6'd0, c_flag}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("c_flag_before_capture", {6'd0, c_flag}, 8'h00);
    @(posedge clk);
    #1;
    check("c_flag_after_release", {6'd0, c_flag}, 8'h03);

    // Randomised sweep over all opcodes.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      op      = 4'($urandom_range(0, 15));
      a       = 4'($urandom_range(0, 15));
      b       = 4'($urandom_range(0, 15));
      flag_in = 2'($urandom_range(0, 3));
      #1;
      model(op, a, b, flag_in[0], m_res, m_c);
      check("rand_res",   {4'd0, alu_result}, {4'd0, m_res});
      check("rand_flags", {6'd0, alu_flags},  {6'd0, (m_res == 4'd0), m_c});
      @(posedge clk);
      #1;
      check("rand_c_flag", {6'd0, c_flag}, {6'd0, (m_res == 4'd0), m_c});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_param.md
# alu_param

Parameterised N-bit arithmetic/logic unit for the datapath: ten operations (logic, add/subtract, increment/decrement, invert, fill-selectable shifts) selected by a 4-bit opcode, with a 1-bit flag input acting as carry-in or operand/fill select. Result and flags are combinational. A registered copy of the flags is held on `C_Flag` for the following instruction.

## Interface
- `N`, default 4: operand and result width (N ≥ 2).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `A`  in  N  operand A.
- `B`  in  N  operand B; also the shift amount for shifts.
- `ALUControl`  in  4  opcode.
- `ALUFlagIn`  in  2  bit 0 = carry-in / select (`cin`); bit 1 reserved, ignored.
- `ALUResult`  out  N  combinational result.
- `ALUFlags`  out  2  combinational flags: bit 1 = Z (result == 0), bit 0 = C (carry/borrow, see below).
- `C_Flag`  out  2  registered copy of `ALUFlags`.

## Operation
All arithmetic is modulo 2^N. `cin` = `ALUFlagIn[0]`. `X` = A when `cin` = 0, B when `cin` = 1.

Opcodes:
- 0 AND: A & B; C = 0.
- 1 OR: A | B; C = 0.
- 2 ADD: A + B + cin; C = carry out of bit N-1.
- 3 INC: X + 1; C = 1 iff X = all-ones.
- 4 DEC: X − 1; C (borrow) = 1 iff X = 0.
- 5 NOT: ~X; C = 0.
- 6 SUB: A − B + cin; C (borrow) = 1 iff A + cin < B, compared unsigned and computed in N+1 bits.
- 7 XOR: A ^ B; C = 0.
- 8 SHL: A << B.
  - `cin` = 0: vacated bits filled with 0.
  - `cin` = 1: vacated bits filled with 1, equivalent to ~(~A << B).
  - C = last bit shifted out; C = 0 if B = 0.
- 9 SHR: A >> B.
  - `cin` = 0: zero fill.
  - `cin` = 1: ones fill, equivalent to ~(~A >> B).
  - C = last bit shifted out; C = 0 if B = 0.
- 10–15: result 0, C = 0, Z = 1.

Shift amount:
- B is treated as an unsigned shift amount.
- B ≥ N shifts every bit out, giving all-fill (all-0 or all-1).
- For B > N, C = 0. For B = N, C = the MSB (SHL) or LSB (SHR) of A.

Flags and reserved input:
- Z = 1 iff `ALUResult` == 0, for every opcode.
- `ALUFlagIn[1]` never affects any output.

## Timing
- `ALUResult` and `ALUFlags` are purely combinational from `A`, `B`, `ALUControl`, `ALUFlagIn`. They settle within the same cycle, with zero clock latency, and are valid at the next rising edge.
- `C_Flag`: on each rising `clk`, if `rst_n` = 0 it loads 2'b00, otherwise it loads `ALUFlags`. Latency is one cycle.
- Reset affects only `C_Flag`. The combinational outputs stay live during reset.
- Reset asserted mid-operation clears `C_Flag` at that edge. The first post-reset capture happens on the first edge with `rst_n` = 1.
- Input changes between edges never glitch `C_Flag`.

## Test plan
- ADD, N=4: A=9, B=8, cin=1 → `ALUResult`=2, `ALUFlags`=2'b01. Next edge: `C_Flag`=2'b01.
- SUB: A=3, B=5, cin=0 → 4'b1110, C=1.
  - Same inputs with cin=1 → 4'b1111, C=1.
  - A=5, B=5, cin=0 → 0, `ALUFlags`=2'b10.
- INC/DEC/NOT select:
  - INC, cin=1, B=15 → 0, `ALUFlags`=2'b11.
  - DEC, cin=0, A=0 → 15, C=1.
  - NOT, cin=1, B=4'b0101 → 4'b1010.
- Shifts:
  - SHL A=4'b0011, B=2, cin=1 → 4'b1111.
  - SHL cin=0 → 4'b1100, C=0.
  - SHR A=4'b1000, B=1, cin=1 → 4'b1100.
  - SHR A=4'b1011, B=5, cin=0 → 0, C=0.
- Logic and illegal opcodes:
  - A=4'b1100, B=4'b1010: AND → 4'b1000, OR → 4'b1110, XOR → 4'b0110, all with C=0.
  - Opcode 12 → 0, `ALUFlags`=2'b10.
  - Toggling `ALUFlagIn[1]` leaves all outputs unchanged.
- Reset:
  - Hold `rst_n`=0 across one edge with `ALUFlags`=2'b11 → `C_Flag`=2'b00.
  - Release `rst_n` → `C_Flag`=2'b11 at the next edge.
  - Randomised sweep of all opcodes (A, B, cin random) checked against the opcode rules above.
